// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment encoding for the seven-segment display path.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_PHASES = 8;

    // Segment bit order within a 7-bit segment word (active high).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] seg_t;

    // Hex glyphs 0-F, with bit SEG_A at the LSB and bit SEG_G at the MSB.
    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t seg;
        unique case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Write port carrying the pending display word and its decimal points.
interface seg7_scan_mux_if;

    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  dp_in;

    modport master (output wr_en, output wr_data, output dp_in);
    modport slave  (input  wr_en, input  wr_data, input  dp_in);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex_in,
    output seg_t       seg
);

    assign seg = hex_to_seg(hex_in);

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver with PWM brightness,
// a dark ghost-guard phase per slot, leading-zero blanking and
// frame-synchronous update of the displayed word.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int PHASE_LEN = 312,
    parameter int PHASE_W   = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_mux_if.slave        wr_bus,
    input  logic [2:0]            brightness,
    input  logic                  lz_blank,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  frame_start
);

    localparam logic [PHASE_W-1:0] CYC_LAST   = PHASE_W'(PHASE_LEN - 1);
    localparam logic [2:0]         PHASE_LAST = 3'(NUM_PHASES - 1);

    // Scan counters.
    logic [PHASE_W-1:0] cyc_cnt;
    logic [2:0]         phase;
    logic [1:0]         digit_idx;

    // Pending word (written any time) and displayed word (frame-locked).
    logic [15:0]           pend_data;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [15:0]           disp_data;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [2:0]            bright_r;
    logic                  lzb_r;

    logic cyc_wrap;
    logic phase_wrap;
    logic boundary;

    assign cyc_wrap   = (cyc_cnt == CYC_LAST);
    assign phase_wrap = (phase == PHASE_LAST);
    assign boundary   = (digit_idx == 2'd0) && (phase == 3'd0) && (cyc_cnt == '0);

    // Cycle / phase / digit counters; phase and digit roll over naturally.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (reset) begin
            cyc_cnt   <= '0;
            phase     <= '0;
            digit_idx <= '0;
        end else begin
            cyc_cnt <= cyc_wrap ? '0 : cyc_cnt + 1'b1;
            if (cyc_wrap) begin
                phase <= phase + 3'd1;
                if (phase_wrap) begin
                    digit_idx <= digit_idx + 2'd1;
                end
            end
        end
    end

    // Pending register: last write wins, never stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
        end else if (wr_bus.wr_en) begin
            pend_data <= wr_bus.wr_data;
            pend_dp   <= wr_bus.dp_in;
        end
    end

    // Display registers load only at the frame boundary, so a write that
    // lands on the boundary cycle is shown one frame later.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_data <= '0;
            disp_dp   <= '0;
            bright_r  <= '0;
            lzb_r     <= 1'b0;
        end else if (boundary) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
            bright_r  <= brightness;
            lzb_r     <= lz_blank;
        end
    end

    // Leading-zero blanking: digit n (3..1) blanks when nibbles n..3 are zero.
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        blank      = '0;
        zero_above = lzb_r;
        for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
            zero_above = zero_above && (disp_data[4*n +: 4] == 4'h0);
            blank[n]   = zero_above;
        end
    end

    // Select the nibble of the digit currently being scanned.
    logic [3:0] cur_nib;
    seg_t       cur_seg;
    assign cur_nib = disp_data[4*digit_idx +: 4];

    seg7_hex_decode u_dec (
        .hex_in (cur_nib),
        .seg    (cur_seg)
    );

    // Next output values: anode lit on phases 1..bright_r, segments and
    // decimal point gated by the anode.
    logic                  an_on;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;
    always_comb begin
        an_on    = (phase != 3'd0) && (phase <= bright_r);
        an_next  = '0;
        seg_next = '0;
        dp_next  = 1'b0;
        if (an_on) begin
            an_next = NUM_DIGITS'(1) << digit_idx;
            dp_next = disp_dp[digit_idx];
            if (!blank[digit_idx]) begin
                seg_next = cur_seg;
            end
        end
    end

    // Registered outputs, one cycle behind the counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_out      <= '0;
            seg_out     <= '0;
            dp_out      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an_out      <= an_next;
            seg_out     <= seg_next;
            dp_out      <= dp_next;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with PHASE_LEN=4 (slot 32, frame 128 cycles).
module tb_seg7_scan_mux;

    localparam int FRAME = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] brightness;
    logic       lz_blank;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [3:0] an_out;
    logic       frame_start;

    seg7_scan_mux_if wr_bus ();

    seg7_scan_mux #(
        .PHASE_LEN (4),
        .PHASE_W   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_bus      (wr_bus),
        .brightness  (brightness),
        .lz_blank    (lz_blank),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .an_out      (an_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;

    // Per-frame capture; index i holds outputs produced from counter offset i.
    logic [6:0] a_seg [FRAME];
    logic [3:0] a_an  [FRAME];
    logic       a_dp  [FRAME];
    logic       a_fs  [FRAME];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic write_word(input logic [15:0] d, input logic [3:0] dp);
        step();
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_data = d;
        wr_bus.dp_in   = dp;
        step();
        wr_bus.wr_en   = 1'b0;
    endtask

    task automatic goto_frame_start();
        while (t % FRAME != 0) step();
    endtask

    // Entered at a boundary cycle; optionally writes on that very cycle.
    task automatic capture_frame(input logic do_wr, input logic [15:0] d, input logic [3:0] dp);
        for (int i = 0; i < FRAME; i++) begin
            if (i == 0 && do_wr) begin
                wr_bus.wr_en   = 1'b1;
                wr_bus.wr_data = d;
                wr_bus.dp_in   = dp;
            end
            step();
            wr_bus.wr_en = 1'b0;
            a_seg[i] = seg_out;
            a_an[i]  = an_out;
            a_dp[i]  = dp_out;
            a_fs[i]  = frame_start;
        end
    endtask

    function automatic int count_an(input int lo, input int hi, input logic [3:0] v);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (a_an[i] == v) c++;
        return c;
    endfunction

    function automatic int count_seg_nz();
        int c = 0;
        for (int i = 0; i < FRAME; i++) if (a_seg[i] != 7'h00) c++;
        return c;
    endfunction

    function automatic int count_dp();
        int c = 0;
        for (int i = 0; i < FRAME; i++) if (a_dp[i]) c++;
        return c;
    endfunction

    function automatic int count_fs();
        int c = 0;
        for (int i = 0; i < FRAME; i++) if (a_fs[i]) c++;
        return c;
    endfunction

    initial begin
        reset          = 1'b1;
        brightness     = 3'd7;
        lz_blank       = 1'b0;
        wr_bus.wr_en   = 1'b0;
        wr_bus.wr_data = '0;
        wr_bus.dp_in   = '0;
        repeat (3) step();
        check("rst_seg", 32'(seg_out), 32'h0);
        check("rst_an", 32'(an_out), 32'h0);
        check("rst_dp", 32'(dp_out), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;
        t = 0;

        // 1: write lands on first boundary -> frame 0 shows 0000, frame 1 shows 1234
        capture_frame(1'b1, 16'h1234, 4'b0000);
        check("f0_fs0", 32'(a_fs[0]), 32'h1);
        check("f0_fs1", 32'(a_fs[1]), 32'h0);
        check("f0_guard_an", 32'(a_an[2]), 32'h0);
        check("f0_d0_an", 32'(a_an[5]), 32'h1);
        check("f0_d0_seg", 32'(a_seg[5]), 32'h3F);
        check("f0_d2_seg", 32'(a_seg[70]), 32'h3F);
        capture_frame(1'b0, 16'h0, 4'h0);
        check("f1_fs0", 32'(a_fs[0]), 32'h1);
        check("f1_d0_on_cnt", 32'(count_an(0, 31, 4'b0001)), 32'd28);
        check("f1_d0_guard", 32'(a_an[3]), 32'h0);
        check("f1_d0_first_an", 32'(a_an[4]), 32'h1);
        check("f1_d0_seg", 32'(a_seg[4]), 32'h66);
        check("f1_d1_an", 32'(a_an[40]), 32'h2);
        check("f1_d1_seg", 32'(a_seg[40]), 32'h4F);
        check("f1_d3_an", 32'(a_an[101]), 32'h8);
        check("f1_d3_seg", 32'(a_seg[101]), 32'h06);

        // 2: brightness 2 then 0
        brightness = 3'd2;
        write_word(16'h0008, 4'b0000);
        goto_frame_start();
        capture_frame(1'b0, 16'h0, 4'h0);
        check("b2_d0_on_cnt", 32'(count_an(0, 31, 4'b0001)), 32'd8);
        check("b2_d0_seg", 32'(a_seg[4]), 32'h7F);
        check("b2_d0_last_on", 32'(a_an[11]), 32'h1);
        check("b2_d0_off_ph3", 32'(a_an[12]), 32'h0);
        check("b2_d0_off_seg", 32'(a_seg[12]), 32'h0);
        check("b2_d1_on_cnt", 32'(count_an(32, 63, 4'b0010)), 32'd8);
        brightness = 3'd0;
        capture_frame(1'b0, 16'h0, 4'h0);
        check("b0_dark_cnt", 32'(count_an(0, FRAME - 1, 4'b0000)), 32'd128);
        check("b0_seg_cnt", 32'(count_seg_nz()), 32'd0);

        // 3: leading-zero blanking
        brightness = 3'd7;
        lz_blank   = 1'b1;
        write_word(16'h0050, 4'b0000);
        goto_frame_start();
        capture_frame(1'b0, 16'h0, 4'h0);
        check("lz_d3_an", 32'(a_an[104]), 32'h8);
        check("lz_d3_seg", 32'(a_seg[104]), 32'h0);
        check("lz_d2_seg", 32'(a_seg[72]), 32'h0);
        check("lz_d1_seg", 32'(a_seg[40]), 32'h6D);
        check("lz_d0_seg", 32'(a_seg[8]), 32'h3F);
        write_word(16'h0000, 4'b0000);
        goto_frame_start();
        capture_frame(1'b0, 16'h0, 4'h0);
        check("lz0_seg_cnt", 32'(count_seg_nz()), 32'd28);
        check("lz0_d0_seg", 32'(a_seg[8]), 32'h3F);
        check("lz0_d1_seg", 32'(a_seg[40]), 32'h0);

        // 4: write coinciding with the boundary is deferred one frame
        lz_blank = 1'b0;
        write_word(16'h1111, 4'b0000);
        goto_frame_start();
        capture_frame(1'b1, 16'hAAAA, 4'b0000);
        check("bnd_cur_d0", 32'(a_seg[8]), 32'h06);
        check("bnd_cur_d3", 32'(a_seg[104]), 32'h06);
        capture_frame(1'b0, 16'h0, 4'h0);
        check("bnd_next_d0", 32'(a_seg[8]), 32'h77);
        check("bnd_next_d2", 32'(a_seg[72]), 32'h77);

        // 5: decimal point on digit 2
        write_word(16'h8888, 4'b0100);
        goto_frame_start();
        capture_frame(1'b0, 16'h0, 4'h0);
        check("dp_cnt", 32'(count_dp()), 32'd28);
        check("dp_d2_on", 32'(a_dp[68]), 32'h1);
        check("dp_d2_guard", 32'(a_dp[64]), 32'h0);
        check("dp_d0_off", 32'(a_dp[4]), 32'h0);
        check("dp_d2_an", 32'(a_an[68]), 32'h4);
        check("dp_d2_seg", 32'(a_seg[68]), 32'h7F);

        // 6: reset at digit 2 / phase 5
        while (t % FRAME != 84) step();
        check("pre_rst_dp", 32'(dp_out), 32'h1);
        reset = 1'b1;
        step();
        check("mid_rst_seg", 32'(seg_out), 32'h0);
        check("mid_rst_an", 32'(an_out), 32'h0);
        check("mid_rst_dp", 32'(dp_out), 32'h0);
        check("mid_rst_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;
        t = 0;
        capture_frame(1'b0, 16'h0, 4'h0);
        check("post_fs0", 32'(a_fs[0]), 32'h1);
        check("post_fs_cnt", 32'(count_fs()), 32'd1);
        check("post_d1_seg", 32'(a_seg[40]), 32'h3F);
        check("post_dp_cnt", 32'(count_dp()), 32'd0);
        capture_frame(1'b0, 16'h0, 4'h0);
        check("post_fs128", 32'(a_fs[0]), 32'h1);
        check("post2_fs_cnt", 32'(count_fs()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
